// File: rtl/cdc_event_feeder.sv
// Source-side event issuer: accumulates event requests in a saturating
// pending counter and launches them as spaced single-cycle pulses into the crossing.
module cdc_event_feeder #(
    parameter int CNT_W = 6,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_req,
    input  logic [2:0]       ev_num,
    input  logic             flush,
    input  logic             cross_full,
    input  logic             ovf_clr,
    output logic             ev_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam logic [CNT_W:0] PEND_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [3:0]     GAP_LD   = 4'((GAP > 0) ? (GAP - 1) : 0);

    state_e           state_q;
    logic [3:0]       gap_cnt_q;
    logic             ev_out_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             launch_s;
    logic             ovf_set_s;
    logic [CNT_W:0]   sum_s;

    // Launch decision and next pending/overflow values; flush drops any same-cycle request.
    always_comb begin
        launch_s  = (state_q == S_IDLE) && (pending_q != '0) && !cross_full && !flush;
        sum_s     = {1'b0, pending_q}
                  + (ev_req ? (CNT_W+1)'(ev_num) : (CNT_W+1)'(0))
                  - (CNT_W+1)'(launch_s);
        ovf_set_s = !flush && (sum_s > PEND_MAX);
        if (flush) begin
            pending_d = '0;
        end else if (ovf_set_s) begin
            pending_d = '1;
        end else begin
            pending_d = sum_s[CNT_W-1:0];
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pending counter and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Launch FSM; ev_out is registered alongside the state so it equals (state == SEND).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= 4'd0;
            ev_out_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch_s) begin
                        state_q  <= S_SEND;
                        ev_out_q <= 1'b1;
                    end else begin
                        ev_out_q <= 1'b0;
                    end
                end
                S_SEND: begin
                    ev_out_q <= 1'b0;
                    if (GAP > 0) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_LD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_GAP: begin
                    ev_out_q <= 1'b0;
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    gap_cnt_q <= 4'd0;
                    ev_out_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ev_out  = ev_out_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;
    assign busy    = (pending_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_cdc_event_feeder.sv
// Bench for cdc_event_feeder: schedule-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cdc_event_feeder;

    localparam int CNT_W = 6;
    localparam int GAP   = 1;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ev_req = 1'b0;
    logic [2:0]       ev_num = 3'd0;
    logic             flush = 1'b0;
    logic             cross_full = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             ev_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    cdc_event_feeder #(.CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ev_req(ev_req), .ev_num(ev_num),
        .flush(flush), .cross_full(cross_full), .ovf_clr(ovf_clr),
        .ev_out(ev_out), .pending(pending), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending count plus a launch schedule expressed in cycle numbers.
    // A pulse decided at the end of cycle c occupies cycle c+1; the next decision
    // may happen no earlier than cycle c+2+GAP.
    int m_pend, m_cyc, m_next_dec, m_send;
    bit m_ovf;

    always @(posedge clk or negedge rst_n) begin
        int nxt;
        bit lau;
        if (!rst_n) begin
            m_pend = 0; m_ovf = 0; m_cyc = 0; m_next_dec = 0; m_send = -100;
        end else begin
            lau = (m_cyc >= m_next_dec) && (m_pend > 0) && !cross_full && !flush;
            nxt = m_pend + ((ev_req && !flush) ? int'(ev_num) : 0) - (lau ? 1 : 0);
            if (flush) nxt = 0;
            if (nxt > MAXV) begin
                nxt = MAXV;
                m_ovf = 1;
            end else if (ovf_clr) begin
                m_ovf = 0;
            end
            m_pend = nxt;
            if (lau) begin
                m_send     = m_cyc + 1;
                m_next_dec = m_cyc + 2 + GAP;
            end
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ev_out", ev_out, (m_cyc == m_send) ? 1 : 0);
            chk("pending", pending, m_pend);
            chk("busy", busy, ((m_pend != 0) || (m_cyc < m_next_dec)) ? 1 : 0);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input int n, input bit fl, input bit fu, input bit cl);
        ev_req = r; ev_num = 3'(n); flush = fl; cross_full = fu; ovf_clr = cl;
    endtask

    initial begin
        int pulses;
        repeat (3) tick();
        chk("rst_ev_out", ev_out, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        // Burst of 3: pulses in cycles 2, 5, 8, busy low from cycle 10
        drive(1, 3, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0);
        chk("burst_c1_pend", pending, 3);
        chk("burst_c1_ev", ev_out, 0);
        tick(); chk("burst_c2_ev", ev_out, 1); chk("burst_c2_pend", pending, 2);
        tick(); chk("burst_c3_ev", ev_out, 0);
        tick(); chk("burst_c4_ev", ev_out, 0);
        tick(); chk("burst_c5_ev", ev_out, 1); chk("burst_c5_pend", pending, 1);
        repeat (3) tick();
        chk("burst_c8_ev", ev_out, 1); chk("burst_c8_pend", pending, 0);
        tick(); chk("burst_c9_busy", busy, 1);
        tick(); chk("burst_c10_busy", busy, 0);

        // Backpressure, then release with a simultaneous request, then flush during SEND
        drive(1, 5, 0, 1, 0);
        tick(); drive(0, 0, 0, 1, 0);
        repeat (20) tick();
        chk("bp_pend", pending, 5);
        chk("bp_ev", ev_out, 0);
        drive(1, 6, 0, 0, 0);
        tick();
        chk("bp_release_ev", ev_out, 1);
        chk("bp_release_pend", pending, 10);
        drive(1, 4, 1, 0, 0);
        tick(); drive(0, 0, 0, 0, 0);
        chk("flush_pend", pending, 0);
        chk("flush_ev", ev_out, 0);
        chk("flush_busy_gap", busy, 1);
        tick(); chk("flush_busy", busy, 0);
        repeat (5) tick();
        chk("flush_quiet", ev_out, 0);

        // Collision: request lands on the launch edge
        drive(1, 1, 0, 0, 0);
        tick(); drive(1, 2, 0, 0, 0);
        tick(); drive(0, 0, 0, 0, 0);
        chk("coll_ev", ev_out, 1);
        chk("coll_pend", pending, 2);
        pulses = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ev_out) pulses++;
        end
        chk("coll_pulses", pulses, 3);
        chk("coll_pend_end", pending, 0);

        // Saturation and sticky overflow
        for (int i = 0; i < 8; i++) begin
            drive(1, 7, 0, 1, 0); tick();
        end
        drive(1, 6, 0, 1, 0); tick();
        chk("sat_62", pending, 62);
        drive(1, 5, 0, 1, 0); tick();
        chk("sat_63", pending, 63);
        chk("sat_ovf", ovf, 1);
        drive(0, 0, 0, 1, 1); tick();
        chk("ovf_clr", ovf, 0);
        drive(1, 1, 0, 1, 1); tick();
        chk("ovf_set_wins", ovf, 1);
        chk("sat_hold", pending, 63);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("sat_flush_pend", pending, 0);
        chk("sat_flush_ovf", ovf, 1);

        // Asynchronous reset during SEND
        drive(1, 3, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !ev_out; i++) tick();
        chk("rst_wait_send", ev_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ev", ev_out, 0);
        chk("midrst_pend", pending, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ev_out) pulses++;
        end
        chk("postrst_pulses", pulses, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 3) == 0, int'($urandom % 8), ($urandom % 40) == 0,
                  ($urandom % 4) == 0, ($urandom % 16) == 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
